// File: rtl/fetch_pc_gen.sv
// Fetch address generator: steps the fetch PC through predictor hints, tracks
// in-flight fetch blocks in a small FIFO and redirects on resolved mispredictions.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'h0000_1000,
  parameter int          QDEPTH   = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] pred_pc,
  input  logic [31:0] pred_target_curr,
  input  logic        pred_taken_curr,
  input  logic        pred_hit_curr,
  output logic        fetch_valid,
  input  logic        res_valid,
  input  logic        res_taken,
  input  logic [31:0] res_target,
  output logic        update_valid,
  output logic [31:0] update_neip,
  output logic [31:0] update_target,
  output logic        update_taken,
  output logic        update_mispred
);

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] q_pc_q  [QDEPTH];
  logic        q_pt_q  [QDEPTH];
  logic [31:0] q_tgt_q [QDEPTH];

  logic        upd_valid_q, upd_valid_d;
  logic [31:0] upd_neip_q, upd_neip_d;
  logic [31:0] upd_target_q, upd_target_d;
  logic        upd_taken_q, upd_taken_d;
  logic        upd_mispred_q, upd_mispred_d;

  logic        pt_s, full_s, empty_s, pop_s, mispred_s, accept_s;
  logic [31:0] head_pc_s, head_tgt_s;
  logic        head_pt_s;

  assign head_pc_s  = q_pc_q[head_q];
  assign head_pt_s  = q_pt_q[head_q];
  assign head_tgt_s = q_tgt_q[head_q];

  assign pt_s      = pred_hit_curr & pred_taken_curr;
  assign full_s    = (count_q == CNT_W'(QDEPTH));
  assign empty_s   = (count_q == '0);
  assign pop_s     = res_valid & ~empty_s;
  // A taken prediction with the wrong target counts as a mispredict too.
  assign mispred_s = pop_s & ((res_taken != head_pt_s) |
                              (res_taken & (res_target != head_tgt_s)));
  assign accept_s  = ~stall & ~full_s & ~mispred_s;

  assign pred_pc        = pc_q;
  assign fetch_valid    = accept_s;
  assign update_valid   = upd_valid_q;
  assign update_neip    = upd_neip_q;
  assign update_target  = upd_target_q;
  assign update_taken   = upd_taken_q;
  assign update_mispred = upd_mispred_q;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (mispred_s) begin
      pc_d    = res_taken ? res_target : (head_pc_s + 32'd8);
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (accept_s) begin
        pc_d   = pt_s ? pred_target_curr : (pc_q + 32'd8);
        tail_d = tail_q + PTR_W'(1);
      end else begin
        pc_d   = pc_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_W'(1);
      end else begin
        head_d = head_q;
      end
      if (accept_s && !pop_s) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop_s && !accept_s) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end
  end

  always_comb begin
    upd_valid_d   = pop_s;
    upd_mispred_d = mispred_s;
    upd_neip_d    = upd_neip_q;
    upd_target_d  = upd_target_q;
    upd_taken_d   = upd_taken_q;
    if (pop_s) begin
      upd_neip_d   = head_pc_s;
      upd_target_d = res_target;
      upd_taken_d  = res_taken;
    end else begin
      upd_neip_d   = upd_neip_q;
      upd_target_d = upd_target_q;
      upd_taken_d  = upd_taken_q;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      upd_valid_q   <= 1'b0;
      upd_neip_q    <= 32'd0;
      upd_target_q  <= 32'd0;
      upd_taken_q   <= 1'b0;
      upd_mispred_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      upd_valid_q   <= upd_valid_d;
      upd_neip_q    <= upd_neip_d;
      upd_target_q  <= upd_target_d;
      upd_taken_q   <= upd_taken_d;
      upd_mispred_q <= upd_mispred_d;
    end
  end

  // Entry storage; a slot is only read after it has been written since the last clear.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]  <= 32'd0;
        q_pt_q[i]  <= 1'b0;
        q_tgt_q[i] <= 32'd0;
      end
    end else if (accept_s) begin
      q_pc_q[tail_q]  <= pc_q;
      q_pt_q[tail_q]  <= pt_s;
      q_tgt_q[tail_q] <= pred_target_curr;
    end else begin
      q_pc_q[tail_q]  <= q_pc_q[tail_q];
      q_pt_q[tail_q]  <= q_pt_q[tail_q];
      q_tgt_q[tail_q] <= q_tgt_q[tail_q];
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with hand-computed expectations.
module tb_fetch_pc_gen;

  logic        CLK = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pred_pc;
  logic [31:0] pred_target_curr;
  logic        pred_taken_curr;
  logic        pred_hit_curr;
  logic        fetch_valid;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        update_valid;
  logic [31:0] update_neip;
  logic [31:0] update_target;
  logic        update_taken;
  logic        update_mispred;

  int errors = 0;
  int checks = 0;

  fetch_pc_gen #(.RESET_PC(32'h0000_1000), .QDEPTH(4)) dut (
    .CLK(CLK), .reset(reset), .stall(stall), .pred_pc(pred_pc),
    .pred_target_curr(pred_target_curr), .pred_taken_curr(pred_taken_curr),
    .pred_hit_curr(pred_hit_curr), .fetch_valid(fetch_valid),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .update_valid(update_valid), .update_neip(update_neip),
    .update_target(update_target), .update_taken(update_taken),
    .update_mispred(update_mispred)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pred(input logic hit, input logic tk, input logic [31:0] tgt);
    pred_hit_curr = hit; pred_taken_curr = tk; pred_target_curr = tgt;
  endtask

  task automatic res(input logic v, input logic tk, input logic [31:0] tgt);
    res_valid = v; res_taken = tk; res_target = tgt;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0;
    pred(1'b0, 1'b0, 32'd0);
    res(1'b0, 1'b0, 32'd0);
    #2;
    check("rst_pc", pred_pc, 32'h0000_1000);
    check("rst_uv", {31'd0, update_valid}, 32'd0);
    check("rst_um", {31'd0, update_mispred}, 32'd0);
    check("rst_neip", update_neip, 32'd0);
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;

    // Sequential fetch from RESET_PC
    #1 check("seq0_pc", pred_pc, 32'h0000_1000);
    check("seq0_fv", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("seq1_pc", pred_pc, 32'h0000_1008);
    check("seq1_fv", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("seq2_pc", pred_pc, 32'h0000_1010);
    pred(1'b1, 1'b1, 32'h0000_2000);
    #1 check("seq2_fv", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("taken_pc", pred_pc, 32'h0000_2000);
    pred(1'b0, 1'b1, 32'h0000_7000);
    #1 check("fill4_fv", {31'd0, fetch_valid}, 32'd1);
    tick();
    // Four entries in flight: 1000,1008,1010(pt),2000
    check("full_pc", pred_pc, 32'h0000_2008);
    check("full_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("full_hold", pred_pc, 32'h0000_2008);
    res(1'b1, 1'b0, 32'd0);
    #1 check("full_pop_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    res(1'b0, 1'b0, 32'd0);
    #1 check("resume_fv", {31'd0, fetch_valid}, 32'd1);
    check("resume_pc", pred_pc, 32'h0000_2008);
    check("ok_uv", {31'd0, update_valid}, 32'd1);
    check("ok_um", {31'd0, update_mispred}, 32'd0);
    check("ok_neip", update_neip, 32'h0000_1000);
    tick();
    check("refill_pc", pred_pc, 32'h0000_2010);
    check("uv_drop", {31'd0, update_valid}, 32'd0);

    // Head 1008 predicted not-taken but resolves taken to 3000
    res(1'b1, 1'b1, 32'h0000_3000);
    #1 check("mp_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("mp_pc", pred_pc, 32'h0000_3000);
    check("mp_uv", {31'd0, update_valid}, 32'd1);
    check("mp_um", {31'd0, update_mispred}, 32'd1);
    check("mp_neip", update_neip, 32'h0000_1008);
    check("mp_tgt", update_target, 32'h0000_3000);
    check("mp_tk", {31'd0, update_taken}, 32'd1);

    // Resolve against the now-empty queue is ignored
    stall = 1'b1;
    res(1'b1, 1'b1, 32'h0000_5000);
    tick();
    check("empty_uv", {31'd0, update_valid}, 32'd0);
    check("empty_pc", pred_pc, 32'h0000_3000);
    stall = 1'b0;

    // Predicted taken to 4000, resolves not-taken -> 3000+8
    res(1'b0, 1'b0, 32'd0);
    pred(1'b1, 1'b1, 32'h0000_4000);
    tick();
    check("pt_pc", pred_pc, 32'h0000_4000);
    pred(1'b0, 1'b0, 32'd0);
    res(1'b1, 1'b0, 32'd0);
    #1 check("nt_fv", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("nt_pc", pred_pc, 32'h0000_3008);
    check("nt_um", {31'd0, update_mispred}, 32'd1);
    check("nt_neip", update_neip, 32'h0000_3000);
    check("nt_tk", {31'd0, update_taken}, 32'd0);

    // Taken with wrong target: predicted 5000, actual 5004
    res(1'b0, 1'b0, 32'd0);
    pred(1'b1, 1'b1, 32'h0000_5000);
    tick();
    pred(1'b0, 1'b0, 32'd0);
    res(1'b1, 1'b1, 32'h0000_5004);
    tick();
    check("tgt_pc", pred_pc, 32'h0000_5004);
    check("tgt_um", {31'd0, update_mispred}, 32'd1);
    check("tgt_tgt", update_target, 32'h0000_5004);

    // Correct taken resolve with simultaneous push
    res(1'b0, 1'b0, 32'd0);
    pred(1'b1, 1'b1, 32'h0000_6000);
    tick();
    pred(1'b0, 1'b0, 32'd0);
    res(1'b1, 1'b1, 32'h0000_6000);
    #1 check("pp_fv", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("pp_pc", pred_pc, 32'h0000_6008);
    check("pp_uv", {31'd0, update_valid}, 32'd1);
    check("pp_um", {31'd0, update_mispred}, 32'd0);
    check("pp_neip", update_neip, 32'h0000_5004);

    // Wrap at the top of the address space
    res(1'b0, 1'b0, 32'd0);
    pred(1'b1, 1'b1, 32'hFFFF_FFF8);
    tick();
    check("top_pc", pred_pc, 32'hFFFF_FFF8);
    pred(1'b0, 1'b0, 32'd0);
    res(1'b1, 1'b0, 32'd0);
    tick();
    check("wrap_pc", pred_pc, 32'h0000_0000);
    check("wrap_uv", {31'd0, update_valid}, 32'd1);
    res(1'b0, 1'b0, 32'd0);

    // Asynchronous reset between edges with entries in flight
    #2 reset = 1'b1;
    #1 check("arst_pc", pred_pc, 32'h0000_1000);
    check("arst_uv", {31'd0, update_valid}, 32'd0);
    tick();
    reset = 1'b0;
    #1 check("post_fv", {31'd0, fetch_valid}, 32'd1);
    check("post_pc", pred_pc, 32'h0000_1000);
    repeat (4) tick();
    check("post_full_pc", pred_pc, 32'h0000_1020);
    check("post_full_fv", {31'd0, fetch_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
